branch_decode_stage: RTL and testbench
======================================

Name: branch_decode_stage

Overview:
- Parametrised second-generation Instruction Decode stage. Sits between IF and EX.
- Resolves a wider branch set in ID against the current register values.
- Forwards every branch downstream as a `NOP`.
- Inserts a configurable number of NOP bubbles after a taken branch, honours a pipeline stall, and keeps a saturating taken-branch count.
- Non-branch instructions pass through with one cycle of delay.

Parameters:
- OP_W, 6, opcode width.
- DATA_W, 10, instruction data/immediate width; also the branch target width.
- REG_W, 8, register operand width.
- FLUSH_CYCLES, 1, number of NOP bubbles forced after a taken branch (1..15).
- CNT_W, 8, width of the taken-branch counter.

Ports:
- Clock  in  1  pipeline clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- iStall  in  1  1 = hold all ID outputs and internal state this cycle.
- iOperation_IF  in  OP_W  opcode from IF.
- iData_IF  in  DATA_W  data/target from IF.
- iRegA  in  REG_W  register A value.
- iRegB  in  REG_W  register B value.
- oOperation_ID  out  OP_W  opcode to EX; `NOP` for branches and bubbles.
- oData_ID  out  DATA_W  data to EX.
- oBranchTaken  out  1  single-cycle pulse: take branch.
- oBranchTarget  out  DATA_W  target address, valid when oBranchTaken=1.
- oFlushBusy  out  1  1 while the bubble counter is nonzero.
- oBranchCount  out  CNT_W  saturating count of taken branches.

Behaviour:
- Reset (Reset=0, asynchronous, any cycle, including mid-flush) drives:
  - oOperation_ID=`NOP`, oData_ID=0, oBranchTaken=0, oBranchTarget=0
  - flush counter=0, oFlushBusy=0, oBranchCount=0
- All outputs are registered. Latency is 1 cycle from IF inputs to outputs.
- Effective op is `NOP` when the flush counter is nonzero (squash); otherwise it is iOperation_IF.
- Branch conditions use the effective op. Opcodes come from the shared defines file; `BBEQ`, `BANE`, `BALT`, `BEQAB` and `JMP` are added there.
  - `BAEQ`: taken if iRegA==0.
  - `BBEQ`: taken if iRegB==0.
  - `BANE`: taken if iRegA!=0.
  - `BALT`: taken if iRegA[REG_W-1]==1 (signed negative).
  - `BEQAB`: taken if iRegA==iRegB.
  - `JMP`: always taken.
- For any branch op, taken or not:
  - oOperation_ID=`NOP`
  - oData_ID=iData_IF
  - oBranchTarget=iData_IF
  - oBranchTaken=condition
- For non-branch ops: oOperation_ID=effective op, oData_ID=iData_IF, oBranchTaken=0. oBranchTarget holds its last value.
- oBranchTaken is high for exactly one cycle per taken branch.
- Flush counter:
  - Loads FLUSH_CYCLES on the clock edge that registers a taken branch.
  - Otherwise decrements by 1 per unstalled cycle while nonzero.
  - oFlushBusy = (counter != 0).
- Ops arriving while the counter is nonzero are squashed: output `NOP`, oData_ID=0. A branch arriving during the flush is therefore ignored.
- Stall (iStall=1, Reset=1): every register holds, including oBranchTaken and the flush counter.
  - A pulse pending on oBranchTaken stays asserted until the first unstalled edge.
  - IF is responsible for holding its inputs during a stall.
- oBranchCount increments on each taken branch and saturates at 2^CNT_W-1 (no wrap).
- A taken branch on the last flush cycle cannot occur, because the op is squashed. A branch exactly one cycle after the counter reaches 0 is evaluated normally.
- Illegal/unknown opcodes are treated as non-branch and passed through.

Test Plan:
1. Reset low, then high; send `BAEQ` data=0x155 with RegA=0 -> next cycle oBranchTaken=1, oBranchTarget=0x155, oOperation_ID=`NOP`, oBranchCount=1; following cycle oBranchTaken=0.
2. FLUSH_CYCLES=2; taken `JMP` 0x020 followed by ADD, SUB, ADD -> outputs `NOP`(jmp), `NOP`, `NOP`, ADD. oFlushBusy=1 for exactly 2 cycles.
3. `BALT` with RegA=0x80 -> taken; with RegA=0x7F -> not taken, oOperation_ID=`NOP`, count unchanged. `BEQAB` with A=B=0x3C -> taken; A=0x3C, B=0x3D -> not taken.
4. Taken `BBEQ` with iStall=1 for 3 cycles after the registering edge -> oBranchTaken stays 1, and the flush counter stays at FLUSH_CYCLES through the stall. Counter decrements after iStall drops.
5. Reset asserted mid-flush (counter=1) -> oFlushBusy, oBranchTaken and oBranchCount go to 0 immediately without a clock edge. After release, the first op passes unsquashed.
6. CNT_W=2; issue 5 taken `JMP`s separated by flush gaps -> oBranchCount reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/branch_decode_stage.sv
// Instruction Decode stage: resolves branches against register values, forwards them
// downstream as NOP, inserts flush bubbles after taken branches and counts them.
`ifndef NOP
`define NOP   6'h00
`endif
`ifndef ADD
`define ADD   6'h01
`endif
`ifndef SUB
`define SUB   6'h02
`endif
`ifndef BAEQ
`define BAEQ  6'h03
`endif
`ifndef BBEQ
`define BBEQ  6'h04
`endif
`ifndef BANE
`define BANE  6'h05
`endif
`ifndef BALT
`define BALT  6'h06
`endif
`ifndef BEQAB
`define BEQAB 6'h07
`endif
`ifndef JMP
`define JMP   6'h08
`endif

module branch_decode_stage #(
  parameter int OP_W         = 6,
  parameter int DATA_W       = 10,
  parameter int REG_W        = 8,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              iStall,
  input  logic [OP_W-1:0]   iOperation_IF,
  input  logic [DATA_W-1:0] iData_IF,
  input  logic [REG_W-1:0]  iRegA,
  input  logic [REG_W-1:0]  iRegB,
  output logic [OP_W-1:0]   oOperation_ID,
  output logic [DATA_W-1:0] oData_ID,
  output logic              oBranchTaken,
  output logic [DATA_W-1:0] oBranchTarget,
  output logic              oFlushBusy,
  output logic [CNT_W-1:0]  oBranchCount
);

  localparam logic [OP_W-1:0]        OP_NOP   = OP_W'(`NOP);
  localparam logic [OP_W-1:0]        OP_BAEQ  = OP_W'(`BAEQ);
  localparam logic [OP_W-1:0]        OP_BBEQ  = OP_W'(`BBEQ);
  localparam logic [OP_W-1:0]        OP_BANE  = OP_W'(`BANE);
  localparam logic [OP_W-1:0]        OP_BALT  = OP_W'(`BALT);
  localparam logic [OP_W-1:0]        OP_BEQAB = OP_W'(`BEQAB);
  localparam logic [OP_W-1:0]        OP_JMP   = OP_W'(`JMP);
  localparam logic [3:0]             FLUSH_LD = 4'(FLUSH_CYCLES);
  localparam logic signed [REG_W-1:0] ZERO_S  = '0;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  logic [OP_W-1:0]   op_q, op_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              taken_q, taken_d;
  logic [DATA_W-1:0] target_q, target_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]  bcnt_q, bcnt_d;

  logic              squash;
  logic [OP_W-1:0]   eff_op;
  logic              is_branch;
  logic              cond;
  logic signed [REG_W-1:0] rega_s;

  assign rega_s = iRegA;
  assign squash = (cnt_q != 4'd0);
  assign eff_op = squash ? OP_NOP : iOperation_IF;

  always_comb begin
    is_branch = 1'b1;
    cond      = 1'b0;
    case (eff_op)
      OP_BAEQ:  cond = (iRegA == '0);
      OP_BBEQ:  cond = (iRegB == '0);
      OP_BANE:  cond = (iRegA != '0);
      OP_BALT:  cond = (rega_s < ZERO_S);
      OP_BEQAB: cond = (iRegA == iRegB);
      OP_JMP:   cond = 1'b1;
      default:  is_branch = 1'b0;
    endcase
  end

  always_comb begin
    op_d     = is_branch ? OP_NOP : eff_op;
    data_d   = squash ? '0 : iData_IF;
    taken_d  = is_branch & cond;
    target_d = is_branch ? iData_IF : target_q;
    bcnt_d   = taken_d ? sat_inc(bcnt_q) : bcnt_q;
    if (taken_d)     cnt_d = FLUSH_LD;
    else if (squash) cnt_d = cnt_q - 4'd1;
    else             cnt_d = cnt_q;
  end

  // ID/EX register boundary; a stall freezes everything including a pending pulse
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      op_q     <= OP_NOP;
      data_q   <= '0;
      taken_q  <= 1'b0;
      target_q <= '0;
      cnt_q    <= 4'd0;
      bcnt_q   <= '0;
    end else if (!iStall) begin
      op_q     <= op_d;
      data_q   <= data_d;
      taken_q  <= taken_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      bcnt_q   <= bcnt_d;
    end
  end

  assign oOperation_ID = op_q;
  assign oData_ID      = data_q;
  assign oBranchTaken  = taken_q;
  assign oBranchTarget = target_q;
  assign oFlushBusy    = (cnt_q != 4'd0);
  assign oBranchCount  = bcnt_q;

endmodule

// File: tb/tb_branch_decode_stage.sv
// Directed self-checking bench for branch_decode_stage (FLUSH_CYCLES=2, CNT_W=2).
`ifndef NOP
`define NOP   6'h00
`endif
`ifndef ADD
`define ADD   6'h01
`endif
`ifndef SUB
`define SUB   6'h02
`endif
`ifndef BAEQ
`define BAEQ  6'h03
`endif
`ifndef BBEQ
`define BBEQ  6'h04
`endif
`ifndef BANE
`define BANE  6'h05
`endif
`ifndef BALT
`define BALT  6'h06
`endif
`ifndef BEQAB
`define BEQAB 6'h07
`endif
`ifndef JMP
`define JMP   6'h08
`endif

module tb_branch_decode_stage;
  logic       Clock;
  logic       Reset;
  logic       iStall;
  logic [5:0] iOperation_IF;
  logic [9:0] iData_IF;
  logic [7:0] iRegA, iRegB;
  logic [5:0] oOperation_ID;
  logic [9:0] oData_ID;
  logic       oBranchTaken;
  logic [9:0] oBranchTarget;
  logic       oFlushBusy;
  logic [1:0] oBranchCount;

  int n_checks = 0;
  int n_fail   = 0;

  branch_decode_stage #(
    .OP_W(6), .DATA_W(10), .REG_W(8), .FLUSH_CYCLES(2), .CNT_W(2)
  ) dut (
    .Clock(Clock), .Reset(Reset), .iStall(iStall),
    .iOperation_IF(iOperation_IF), .iData_IF(iData_IF),
    .iRegA(iRegA), .iRegB(iRegB),
    .oOperation_ID(oOperation_ID), .oData_ID(oData_ID),
    .oBranchTaken(oBranchTaken), .oBranchTarget(oBranchTarget),
    .oFlushBusy(oFlushBusy), .oBranchCount(oBranchCount)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic drive(input logic [5:0] op, input logic [9:0] d,
                       input logic [7:0] a, input logic [7:0] b);
    iOperation_IF = op; iData_IF = d; iRegA = a; iRegB = b;
  endtask

  task automatic step();
    @(posedge Clock); #1;
  endtask

  task automatic do_reset();
    drive(`NOP, 10'h000, 8'h01, 8'h01);
    iStall = 1'b0;
    Reset = 1'b0;
    step();
    Reset = 1'b1;
  endtask

  task automatic test_reset();
    Reset = 1'b1; iStall = 1'b0;
    drive(`NOP, 10'h000, 8'h01, 8'h01);
    #2 Reset = 1'b0;
    #1;
    n_checks++; if (oOperation_ID !== `NOP) begin n_fail++; $display("FAIL reset_op got %0h exp %0h", oOperation_ID, `NOP); end
    n_checks++; if (oData_ID !== 10'h0) begin n_fail++; $display("FAIL reset_data got %0h exp 0", oData_ID); end
    n_checks++; if (oBranchTaken !== 1'b0) begin n_fail++; $display("FAIL reset_taken got %0b exp 0", oBranchTaken); end
    n_checks++; if (oBranchTarget !== 10'h0) begin n_fail++; $display("FAIL reset_target got %0h exp 0", oBranchTarget); end
    n_checks++; if (oFlushBusy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b exp 0", oFlushBusy); end
    n_checks++; if (oBranchCount !== 2'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", oBranchCount); end
    step();
    Reset = 1'b1;
  endtask

  task automatic test_baeq();
    do_reset();
    drive(`BAEQ, 10'h155, 8'h00, 8'h07);
    step();
    n_checks++; if (oBranchTaken !== 1'b1) begin n_fail++; $display("FAIL baeq_taken got %0b exp 1", oBranchTaken); end
    n_checks++; if (oBranchTarget !== 10'h155) begin n_fail++; $display("FAIL baeq_target got %0h exp 155", oBranchTarget); end
    n_checks++; if (oOperation_ID !== `NOP) begin n_fail++; $display("FAIL baeq_op got %0h exp 0", oOperation_ID); end
    n_checks++; if (oBranchCount !== 2'd1) begin n_fail++; $display("FAIL baeq_count got %0d exp 1", oBranchCount); end
    drive(`NOP, 10'h000, 8'h00, 8'h00);
    step();
    n_checks++; if (oBranchTaken !== 1'b0) begin n_fail++; $display("FAIL baeq_pulse got %0b exp 0", oBranchTaken); end
  endtask

  task automatic test_flush();
    do_reset();
    drive(`JMP, 10'h020, 8'h11, 8'h22);
    step();
    n_checks++; if (oOperation_ID !== `NOP || oBranchTaken !== 1'b1 || oFlushBusy !== 1'b1) begin n_fail++;
      $display("FAIL flush_jmp got op=%0h tk=%0b busy=%0b exp op=0 tk=1 busy=1", oOperation_ID, oBranchTaken, oFlushBusy); end
    n_checks++; if (oBranchTarget !== 10'h020) begin n_fail++; $display("FAIL flush_target got %0h exp 020", oBranchTarget); end
    drive(`ADD, 10'h011, 8'h11, 8'h22);
    step();
    n_checks++; if (oOperation_ID !== `NOP || oData_ID !== 10'h0 || oFlushBusy !== 1'b1 || oBranchTaken !== 1'b0) begin n_fail++;
      $display("FAIL flush_sq1 got op=%0h d=%0h busy=%0b tk=%0b exp op=0 d=0 busy=1 tk=0", oOperation_ID, oData_ID, oFlushBusy, oBranchTaken); end
    drive(`SUB, 10'h022, 8'h11, 8'h22);
    step();
    n_checks++; if (oOperation_ID !== `NOP || oData_ID !== 10'h0 || oFlushBusy !== 1'b0) begin n_fail++;
      $display("FAIL flush_sq2 got op=%0h d=%0h busy=%0b exp op=0 d=0 busy=0", oOperation_ID, oData_ID, oFlushBusy); end
    drive(`ADD, 10'h033, 8'h11, 8'h22);
    step();
    n_checks++; if (oOperation_ID !== `ADD || oData_ID !== 10'h033) begin n_fail++;
      $display("FAIL flush_pass got op=%0h d=%0h exp op=1 d=033", oOperation_ID, oData_ID); end
    n_checks++; if (oBranchTarget !== 10'h020) begin n_fail++; $display("FAIL flush_tgt_hold got %0h exp 020", oBranchTarget); end
    drive(6'h3F, 10'h3C3, 8'h00, 8'h00);
    step();
    n_checks++; if (oOperation_ID !== 6'h3F || oData_ID !== 10'h3C3 || oBranchTaken !== 1'b0) begin n_fail++;
      $display("FAIL illegal_pass got op=%0h d=%0h tk=%0b exp op=3f d=3c3 tk=0", oOperation_ID, oData_ID, oBranchTaken); end
  endtask

  task automatic test_conditions();
    do_reset();
    drive(`BALT, 10'h1AA, 8'h7F, 8'h00);
    step();
    n_checks++; if (oBranchTaken !== 1'b0 || oOperation_ID !== `NOP || oBranchCount !== 2'd0) begin n_fail++;
      $display("FAIL balt_pos got tk=%0b op=%0h cnt=%0d exp tk=0 op=0 cnt=0", oBranchTaken, oOperation_ID, oBranchCount); end
    n_checks++; if (oBranchTarget !== 10'h1AA || oFlushBusy !== 1'b0) begin n_fail++;
      $display("FAIL balt_pos_tgt got tgt=%0h busy=%0b exp tgt=1aa busy=0", oBranchTarget, oFlushBusy); end
    drive(`BALT, 10'h1AB, 8'h80, 8'h00);
    step();
    n_checks++; if (oBranchTaken !== 1'b1 || oBranchCount !== 2'd1 || oBranchTarget !== 10'h1AB) begin n_fail++;
      $display("FAIL balt_neg got tk=%0b cnt=%0d tgt=%0h exp tk=1 cnt=1 tgt=1ab", oBranchTaken, oBranchCount, oBranchTarget); end
    drive(`NOP, 10'h000, 8'h00, 8'h00);
    step(); step();
    drive(`BEQAB, 10'h0F0, 8'h3C, 8'h3C);
    step();
    n_checks++; if (oBranchTaken !== 1'b1 || oBranchCount !== 2'd2) begin n_fail++;
      $display("FAIL beqab_eq got tk=%0b cnt=%0d exp tk=1 cnt=2", oBranchTaken, oBranchCount); end
    drive(`NOP, 10'h000, 8'h00, 8'h00);
    step(); step();
    drive(`BEQAB, 10'h0F1, 8'h3C, 8'h3D);
    step();
    n_checks++; if (oBranchTaken !== 1'b0 || oBranchCount !== 2'd2 || oBranchTarget !== 10'h0F1) begin n_fail++;
      $display("FAIL beqab_ne got tk=%0b cnt=%0d tgt=%0h exp tk=0 cnt=2 tgt=0f1", oBranchTaken, oBranchCount, oBranchTarget); end
    drive(`BANE, 10'h0F2, 8'h00, 8'h00);
    step();
    n_checks++; if (oBranchTaken !== 1'b0) begin n_fail++; $display("FAIL bane_zero got %0b exp 0", oBranchTaken); end
    drive(`BBEQ, 10'h0F3, 8'h00, 8'h01);
    step();
    n_checks++; if (oBranchTaken !== 1'b0) begin n_fail++; $display("FAIL bbeq_nz got %0b exp 0", oBranchTaken); end
    drive(`BANE, 10'h0F4, 8'h05, 8'h00);
    step();
    n_checks++; if (oBranchTaken !== 1'b1 || oBranchCount !== 2'd3) begin n_fail++;
      $display("FAIL bane_nz got tk=%0b cnt=%0d exp tk=1 cnt=3", oBranchTaken, oBranchCount); end
  endtask

  task automatic test_stall();
    do_reset();
    drive(`BBEQ, 10'h2A5, 8'h09, 8'h00);
    step();
    n_checks++; if (oBranchTaken !== 1'b1 || oFlushBusy !== 1'b1) begin n_fail++;
      $display("FAIL stall_reg got tk=%0b busy=%0b exp tk=1 busy=1", oBranchTaken, oFlushBusy); end
    iStall = 1'b1;
    drive(`ADD, 10'h055, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (oBranchTaken !== 1'b1 || oFlushBusy !== 1'b1 || oOperation_ID !== `NOP || oBranchCount !== 2'd1) begin n_fail++;
        $display("FAIL stall_hold%0d got tk=%0b busy=%0b op=%0h cnt=%0d exp tk=1 busy=1 op=0 cnt=1", i, oBranchTaken, oFlushBusy, oOperation_ID, oBranchCount); end
    end
    iStall = 1'b0;
    step();
    n_checks++; if (oBranchTaken !== 1'b0 || oFlushBusy !== 1'b1 || oOperation_ID !== `NOP || oData_ID !== 10'h0) begin n_fail++;
      $display("FAIL stall_rel1 got tk=%0b busy=%0b op=%0h d=%0h exp tk=0 busy=1 op=0 d=0", oBranchTaken, oFlushBusy, oOperation_ID, oData_ID); end
    step();
    n_checks++; if (oFlushBusy !== 1'b0) begin n_fail++; $display("FAIL stall_rel2 got busy=%0b exp 0", oFlushBusy); end
    step();
    n_checks++; if (oOperation_ID !== `ADD || oData_ID !== 10'h055) begin n_fail++;
      $display("FAIL stall_pass got op=%0h d=%0h exp op=1 d=055", oOperation_ID, oData_ID); end
  endtask

  task automatic test_reset_mid_flush();
    do_reset();
    drive(`JMP, 10'h100, 8'h00, 8'h00);
    step();
    drive(`SUB, 10'h0AB, 8'h00, 8'h00);
    step();
    n_checks++; if (oFlushBusy !== 1'b1 || oBranchCount !== 2'd1) begin n_fail++;
      $display("FAIL midflush_pre got busy=%0b cnt=%0d exp busy=1 cnt=1", oFlushBusy, oBranchCount); end
    #2 Reset = 1'b0;
    #1;
    n_checks++; if (oFlushBusy !== 1'b0 || oBranchTaken !== 1'b0 || oBranchCount !== 2'd0 || oBranchTarget !== 10'h0) begin n_fail++;
      $display("FAIL midflush_async got busy=%0b tk=%0b cnt=%0d tgt=%0h exp 0 0 0 0", oFlushBusy, oBranchTaken, oBranchCount, oBranchTarget); end
    step();
    Reset = 1'b1;
    step();
    n_checks++; if (oOperation_ID !== `SUB || oData_ID !== 10'h0AB) begin n_fail++;
      $display("FAIL midflush_after got op=%0h d=%0h exp op=2 d=0ab", oOperation_ID, oData_ID); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(`JMP, 10'(i + 16), 8'h00, 8'h00);
      step();
      n_checks++; if (oBranchTaken !== 1'b1 || oBranchCount !== exp_cnt[i]) begin n_fail++;
        $display("FAIL sat_jmp%0d got tk=%0b cnt=%0d exp tk=1 cnt=%0d", i, oBranchTaken, oBranchCount, exp_cnt[i]); end
      drive(`JMP, 10'h3FF, 8'h00, 8'h00);
      step(); step();
    end
  endtask

  initial begin
    test_reset();
    test_baeq();
    test_flush();
    test_conditions();
    test_stall();
    test_reset_mid_flush();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
